// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller.
// Holds the FSM state enum, ALU control codes, opcode constants, datapath
// select encodings and the ALU-decoder operation class.
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN adds the S_JAL state.
package multicycle_ctrl_pkg;

   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned OPCODE_W   = 7;
   localparam int unsigned FUNCT3_W   = 3;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned STATE_W    = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9
`ifdef MULTICYCLE_CTRL_JAL_EN
      ,
      S_JAL       = 4'd10
`endif
   } state_t;

   // Which decode table the ALU operation comes from
   typedef enum logic [1:0] {
      CLS_ADD    = 2'd0,
      CLS_RTYPE  = 2'd1,
      CLS_ITYPE  = 2'd2,
      CLS_BRANCH = 2'd3
   } alu_class_t;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;

   localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

   localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
   localparam logic [SEL_W-1:0] SRC_A_REG    = 2'b01;
   localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b10;

   localparam logic [SEL_W-1:0] SRC_B_REG    = 2'b00;
   localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALU_OUT  = 2'b00;
   localparam logic [SEL_W-1:0] RES_MEM_DATA = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU_LIVE = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation decoder.
// Ports: op_class (decode table), funct3, funct7_b5 in;
//        alu_control (4-bit ALU op), funct_illegal (unsupported funct) out.
module alu_op_decoder
   import multicycle_ctrl_pkg::*;
(
   input  alu_class_t                op_class,
   input  logic [FUNCT3_W-1:0]       funct3,
   input  logic                      funct7_b5,
   output logic [ALU_CTRL_W-1:0]     alu_control,
   output logic                      funct_illegal
);

   always_comb begin
      alu_control   = ALU_ADD;
      funct_illegal = 1'b0;
      case (op_class)
         CLS_RTYPE: begin
            case (funct3)
               3'b000:  alu_control = funct7_b5 ? ALU_SUB : ALU_ADD;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: funct_illegal = 1'b1;
            endcase
         end
         // funct7_b5 carries immediate bits here, so it is not consulted
         CLS_ITYPE: begin
            case (funct3)
               3'b000:  alu_control = ALU_ADD;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: funct_illegal = 1'b1;
            endcase
         end
         // Only beq is supported; compare via subtract and the zero flag
         CLS_BRANCH: begin
            alu_control = ALU_SUB;
            if (funct3 != 3'b000) funct_illegal = 1'b1;
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the RISC-V subset core.
// Sequences fetch/decode/execute through the shared datapath; outputs are
// decoded combinationally from state (plus mem_ready/zero where used).
// Ports: clk, reset (sync, active-high), opcode, funct3, funct7_b5, zero,
//        mem_ready in; alu_control, alu_src_a, alu_src_b, result_src,
//        pc_src, i_or_d, pc_write, ir_write, reg_write, mem_read,
//        mem_write, illegal, instr_done out.
// Optional feature macro: MULTICYCLE_CTRL_JAL_EN enables the JAL state;
// without it opcode 1101111 is reported illegal.
module multicycle_control
   import multicycle_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [OPCODE_W-1:0]    opcode,
   input  logic [FUNCT3_W-1:0]    funct3,
   input  logic                   funct7_b5,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic [ALU_CTRL_W-1:0]  alu_control,
   output logic [SEL_W-1:0]       alu_src_a,
   output logic [SEL_W-1:0]       alu_src_b,
   output logic [SEL_W-1:0]       result_src,
   output logic                   pc_src,
   output logic                   i_or_d,
   output logic                   pc_write,
   output logic                   ir_write,
   output logic                   reg_write,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   illegal,
   output logic                   instr_done
);

   state_t                  state;
   state_t                  state_next;
   alu_class_t              dec_class;
   logic [ALU_CTRL_W-1:0]   dec_alu_control;
   logic                    funct_illegal;
   logic                    opcode_known;
   logic                    decode_illegal;

   // In DECODE the class comes from the opcode (legality check only);
   // in execute states it comes from the state itself.
   always_comb begin
      dec_class = CLS_ADD;
      case (state)
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:  dec_class = CLS_RTYPE;
               OP_ITYPE:  dec_class = CLS_ITYPE;
               OP_BRANCH: dec_class = CLS_BRANCH;
               default:   dec_class = CLS_ADD;
            endcase
         end
         S_EXEC_R: dec_class = CLS_RTYPE;
         S_EXEC_I: dec_class = CLS_ITYPE;
         S_BRANCH: dec_class = CLS_BRANCH;
         default:  dec_class = CLS_ADD;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .op_class      (dec_class),
      .funct3        (funct3),
      .funct7_b5     (funct7_b5),
      .alu_control   (dec_alu_control),
      .funct_illegal (funct_illegal)
   );

   // Opcodes this controller can sequence
   always_comb begin
      opcode_known = 1'b0;
      case (opcode)
         OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH: opcode_known = 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
         OP_JAL:  opcode_known = 1'b1;
`endif
         default: opcode_known = 1'b0;
      endcase
   end

   assign decode_illegal = !opcode_known || funct_illegal;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH: if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            state_next = S_FETCH;
            if (!decode_illegal) begin
               case (opcode)
                  OP_RTYPE:          state_next = S_EXEC_R;
                  OP_ITYPE:          state_next = S_EXEC_I;
                  OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                  OP_BRANCH:         state_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
                  OP_JAL:            state_next = S_JAL;
`endif
                  default:           state_next = S_FETCH;
               endcase
            end
         end
         S_MEM_ADDR:  state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
         S_EXEC_R:    state_next = S_ALU_WB;
         S_EXEC_I:    state_next = S_ALU_WB;
         default:     state_next = S_FETCH;
      endcase
   end

   // Output decode; reset forces every enable and select to its idle value
   always_comb begin
      alu_control = ALU_ADD;
      alu_src_a   = SRC_A_PC;
      alu_src_b   = SRC_B_REG;
      result_src  = RES_ALU_OUT;
      pc_src      = 1'b0;
      i_or_d      = 1'b0;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      illegal     = 1'b0;
      instr_done  = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRC_B_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            // Branch target is computed here and latched in ALUOut
            S_DECODE: begin
               alu_src_a  = SRC_A_OLD_PC;
               alu_src_b  = SRC_B_IMM;
               illegal    = decode_illegal;
               instr_done = decode_illegal;
            end
            S_MEM_ADDR: begin
               alu_src_a = SRC_A_REG;
               alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               result_src = RES_MEM_DATA;
               instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               instr_done = mem_ready;
            end
            S_EXEC_R: begin
               alu_src_a   = SRC_A_REG;
               alu_src_b   = SRC_B_REG;
               alu_control = dec_alu_control;
            end
            S_EXEC_I: begin
               alu_src_a   = SRC_A_REG;
               alu_src_b   = SRC_B_IMM;
               alu_control = dec_alu_control;
            end
            S_ALU_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a   = SRC_A_REG;
               alu_src_b   = SRC_B_REG;
               alu_control = dec_alu_control;
               pc_write    = zero;
               pc_src      = 1'b1;
               instr_done  = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            // Link value PC+4 goes straight to the register file while the
            // jump target computed in DECODE is taken from ALUOut
            S_JAL: begin
               alu_src_a  = SRC_A_OLD_PC;
               alu_src_b  = SRC_B_FOUR;
               reg_write  = 1'b1;
               result_src = RES_ALU_LIVE;
               pc_write   = 1'b1;
               pc_src     = 1'b1;
               instr_done = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
